memvga_glyph_seq: RTL and testbench

- Sequencer that owns the VGA glyph ROM read port: 32 words x 8 bits, 16 glyphs "0123456789+-*/=!", 2 words per glyph, combinational read (rd follows ra in the same cycle).
- On a glyph request it drives the two ROM addresses, assembles the 3x5 bitmap, and serialises it pixel by pixel to the VGA pixel path with a valid/ready handshake.
- Optional spacer column for inter-character gaps.

---
 rtl/memvga_glyph_seq.sv | 155 +++++++++++++++
 tb/tb_memvga_glyph_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memvga_glyph_seq.sv
// -----------------------------------------------------------------------------
// memvga_glyph_seq
//
// Owns the read port of the 32x8 VGA glyph ROM (16 glyphs, 2 words each,
// combinational read). On an accepted glyph request it fetches both ROM words,
// assembles the 3x5 bitmap and streams it out one pixel per handshake,
// row-major, MSB first. With SPACER=1 every row gets a blank 4th column so
// consecutive characters are separated on screen.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   req/code   glyph request and glyph index (0..15), taken when req && ready
//   ready      high only while idle
//   ra/rd      ROM address (registered) / ROM data (combinational from ra)
//   pix_valid  pix, pix_row, pix_col carry a pixel
//   pix_ready  downstream accepts the pixel when pix_valid && pix_ready
//   pix        pixel on/off
//   pix_row    row 0..4
//   pix_col    column 0..2, or 3 for the spacer column
//   done       one-cycle pulse after the last pixel of a glyph is accepted
// -----------------------------------------------------------------------------
module memvga_glyph_seq #(
  parameter bit SPACER = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [3:0] code,
  output logic       ready,
  output logic [4:0] ra,
  input  logic [7:0] rd,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       pix,
  output logic [2:0] pix_row,
  output logic [1:0] pix_col,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH_HI,
    FETCH_LO,
    SHIFT
  } state_t;

  localparam logic [1:0] LAST_COL = SPACER ? 2'd3 : 2'd2;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  code_q;
  logic [15:0] bitmap;
  logic [2:0]  row;
  logic [1:0]  col;

  logic        accept;
  logic        pix_hs;
  logic        col_last;
  logic        glyph_last;
  logic [3:0]  bit_idx;

  assign accept     = (state == IDLE) && req;
  assign pix_hs     = (state == SHIFT) && pix_ready;
  assign col_last   = (col == LAST_COL);
  assign glyph_last = col_last && (row == 3'd4);

  // Row-major bit index; the largest real pixel is row 4, col 2 -> 14.
  assign bit_idx = ({1'b0, row} * 4'd3) + {2'b00, col};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values of the others regardless of order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps this block free of latches
  // even on paths where no case arm assigns the output.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = FETCH_HI;
      FETCH_HI: state_nxt = FETCH_LO;
      FETCH_LO: state_nxt = SHIFT;
      SHIFT:    if (pix_hs && glyph_last) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: latched code, ROM address, bitmap, pixel cursor, done pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_q <= 4'd0;
      ra     <= 5'd0;
      bitmap <= 16'd0;
      row    <= 3'd0;
      col    <= 2'd0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            code_q <= code;
            ra     <= {code, 1'b0};
          end
        end
        FETCH_HI: begin
          bitmap[15:8] <= rd;
          ra           <= {code_q, 1'b1};
        end
        FETCH_LO: begin
          bitmap[7:0] <= rd;
          row         <= 3'd0;
          col         <= 2'd0;
        end
        SHIFT: begin
          if (pix_ready) begin
            if (col_last) begin
              col <= 2'd0;
              row <= row + 3'd1;
            end else begin
              col <= col + 2'd1;
            end
            done <= glyph_last;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ready     = (state == IDLE);
    pix_valid = (state == SHIFT);
    pix_row   = row;
    pix_col   = col;
    pix       = 1'b0;
    // Column 3 only exists with SPACER=1 and is always blank.
    if ((state == SHIFT) && (col != 2'd3)) pix = bitmap[4'd15 - bit_idx];
  end

endmodule

// File: tb/tb_memvga_glyph_seq.sv
// -----------------------------------------------------------------------------
// tb_memvga_glyph_seq
//
// Directed bench for memvga_glyph_seq. Two instances share a ROM model:
// dut0 with SPACER=0 and dut1 with SPACER=1. 'sel' routes req to one of them
// and picks which one's outputs are observed. Expected pixel streams are
// hand-written glyph bit patterns (row-major, MSB = row 0 col 0).
// -----------------------------------------------------------------------------
module tb_memvga_glyph_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic [3:0] code;
  logic       pix_ready;
  bit         sel;

  logic [7:0] mem [32];

  logic       req0, req1;
  logic       ready0, ready1;
  logic [4:0] ra0, ra1;
  logic [7:0] rd0, rd1;
  logic       valid0, valid1;
  logic       pix0, pix1;
  logic [2:0] row0, row1;
  logic [1:0] col0, col1;
  logic       done0, done1;

  logic       m_ready, m_valid, m_pix, m_done;
  logic [4:0] m_ra;
  logic [2:0] m_row;
  logic [1:0] m_col;

  int n_pass  = 0;
  int n_total = 0;

  // Hand-drawn glyphs, 15 bits = rows 0..4 of 3 columns each.
  localparam logic [14:0] G_ONE  = 15'b101_001_010_011_110; // mem[2]=A5 mem[3]=3C
  localparam logic [14:0] G_ZERO = 15'b111_101_101_101_111; // mem[0]=F6 mem[1]=DE
  localparam logic [14:0] G_NINE = 15'b111_101_111_001_111; // mem[18]=F7 mem[19]=9E
  localparam logic [14:0] G_FULL = 15'b111_111_111_111_111; // mem[30]=FF mem[31]=FE

  always #5 clk = ~clk;

  assign req0 = req & ~sel;
  assign req1 = req & sel;
  assign rd0  = mem[ra0];
  assign rd1  = mem[ra1];

  assign m_ready = sel ? ready1 : ready0;
  assign m_valid = sel ? valid1 : valid0;
  assign m_pix   = sel ? pix1   : pix0;
  assign m_done  = sel ? done1  : done0;
  assign m_ra    = sel ? ra1    : ra0;
  assign m_row   = sel ? row1   : row0;
  assign m_col   = sel ? col1   : col0;

  memvga_glyph_seq #(.SPACER(1'b0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .req       (req0),
    .code      (code),
    .ready     (ready0),
    .ra        (ra0),
    .rd        (rd0),
    .pix_valid (valid0),
    .pix_ready (pix_ready),
    .pix       (pix0),
    .pix_row   (row0),
    .pix_col   (col0),
    .done      (done0)
  );

  memvga_glyph_seq #(.SPACER(1'b1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .req       (req1),
    .code      (code),
    .ready     (ready1),
    .ra        (ra1),
    .rd        (rd1),
    .pix_valid (valid1),
    .pix_ready (pix_ready),
    .pix       (pix1),
    .pix_row   (row1),
    .pix_col   (col1),
    .done      (done1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s (sel=%0d t=%0t): got %0h expected %0h", tag, sel, $time, got, exp);
    else
      n_pass++;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(m_ready), 32'd1);
    check({tag, "_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_done"},  32'(m_done),  32'd0);
    check({tag, "_ra"},    32'(m_ra),    32'd0);
    check({tag, "_pix"},   32'(m_pix),   32'd0);
  endtask

  // Caller raises req with 'code' during an idle cycle; this covers the
  // acceptance edge plus the two fetch cycles.
  task automatic fetch(input logic [3:0] c, input bit keep_req);
    @(posedge clk); #1;
    check("fetch_hi_ready", 32'(m_ready), 32'd0);
    check("fetch_hi_ra",    32'(m_ra),    32'({c, 1'b0}));
    if (!keep_req) req = 1'b0;
    @(posedge clk); #1;
    check("fetch_lo_ra",    32'(m_ra),    32'({c, 1'b1}));
    check("fetch_lo_valid", 32'(m_valid), 32'd0);
  endtask

  // Consumes one glyph from the first SHIFT cycle (acceptance + 3) up to and
  // including the done cycle; exp_done is counted from the acceptance edge.
  task automatic stream(input logic [14:0] g, input bit toggle, input int exp_done);
    int   k, cyc, ncol, r, c;
    logic pr_now, exp_pix;
    ncol   = sel ? 4 : 3;
    k      = 0;
    cyc    = 2;
    pr_now = 1'b0;
    while (k < 5 * ncol && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      r = k / ncol;
      c = k % ncol;
      exp_pix = (c == 3) ? 1'b0 : g[14 - (3 * r + c)];
      check("valid", 32'(m_valid), 32'd1);
      check("row",   32'(m_row),   32'(r));
      check("col",   32'(m_col),   32'(c));
      check("pix",   32'(m_pix),   32'(exp_pix));
      check("busy_ready", 32'(m_ready), 32'd0);
      check("busy_done",  32'(m_done),  32'd0);
      pr_now    = toggle ? ~pr_now : 1'b1;
      pix_ready = pr_now;
      if (pr_now) k++;
    end
    @(posedge clk); #1;
    cyc++;
    check("done",       32'(m_done),  32'd1);
    check("done_cycle", 32'(cyc),     32'(exp_done));
    check("done_ready", 32'(m_ready), 32'd1);
    check("done_valid", 32'(m_valid), 32'd0);
    pix_ready = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    req       = 1'b0;
    code      = 4'd0;
    pix_ready = 1'b1;
    sel       = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0]  = 8'hF6; mem[1]  = 8'hDE;
    mem[2]  = 8'hA5; mem[3]  = 8'h3C;
    mem[18] = 8'hF7; mem[19] = 8'h9E;
    mem[30] = 8'hFF; mem[31] = 8'hFE;

    // Reset held, then released with no request.
    repeat (2) @(posedge clk);
    #1;
    sel = 1'b0; check_idle("in_reset0");
    sel = 1'b1; check_idle("in_reset1");
    reset = 1'b1;
    @(posedge clk); #1;
    sel = 1'b0; check_idle("post_reset0");
    sel = 1'b1; check_idle("post_reset1");

    // SPACER=0, glyph 1, pix_ready high: done at acceptance + 18.
    sel  = 1'b0;
    req  = 1'b1;
    code = 4'd1;
    fetch(4'd1, 1'b0);
    stream(G_ONE, 1'b0, 18);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(m_done), 32'd0);

    // Same glyph with pix_ready toggling: 15 handshakes on alternate cycles.
    req  = 1'b1;
    code = 4'd1;
    fetch(4'd1, 1'b0);
    stream(G_ONE, 1'b1, 32);

    // SPACER=1, glyph 15: 20 pixels, col 3 always blank, done at + 23.
    sel  = 1'b1;
    req  = 1'b1;
    code = 4'd15;
    fetch(4'd15, 1'b0);
    stream(G_FULL, 1'b0, 23);

    // Back-to-back with req held high; code changes while busy only take
    // effect at the next acceptance, which lands in the done cycle.
    sel  = 1'b0;
    req  = 1'b1;
    code = 4'd0;
    fetch(4'd0, 1'b1);
    code = 4'd9;
    stream(G_ZERO, 1'b0, 18);
    fetch(4'd9, 1'b0);
    stream(G_NINE, 1'b0, 18);

    // req pulsed mid-SHIFT with another code is ignored.
    req  = 1'b1;
    code = 4'd1;
    fetch(4'd1, 1'b0);
    fork
      stream(G_ONE, 1'b0, 18);
      begin
        repeat (6) @(posedge clk);
        #2;
        req  = 1'b1;
        code = 4'd7;
        @(posedge clk);
        #2;
        req  = 1'b0;
      end
    join

    // Reset asserted mid-SHIFT: immediate return to reset values, no done.
    req  = 1'b1;
    code = 4'd1;
    fetch(4'd1, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_idle("mid_reset");
    @(posedge clk); #1;
    check("mid_reset_no_done", 32'(m_done), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle("after_mid_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
